// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and controller outputs.
// The perf_* counters exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_if #(
  parameter int REG_AW  = 5,
  parameter int NPCOP_W = 2
);
  logic [REG_AW-1:0]  id_ex_rt;
  logic               id_ex_mem_read;
  logic [REG_AW-1:0]  if_id_rs;
  logic [REG_AW-1:0]  if_id_rt;
  logic               if_id_use_rs;
  logic               if_id_use_rt;
  logic [NPCOP_W-1:0] npc_op;
  logic               dmem_busy;
  logic               stall_if;
  logic               bubble_ex;
  logic               flush_ifid;
  logic               freeze_all;
  logic [1:0]         state_o;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]        perf_stall;
  logic [31:0]        perf_flush;
  logic [31:0]        perf_freeze;
`endif

  modport master (
    output id_ex_rt, id_ex_mem_read, if_id_rs, if_id_rt,
    output if_id_use_rs, if_id_use_rt, npc_op, dmem_busy,
    input  stall_if, bubble_ex, flush_ifid, freeze_all, state_o
`ifdef HAZ_PERF_CNT_EN
    , input perf_stall, perf_flush, perf_freeze
`endif
  );

  modport slave (
    input  id_ex_rt, id_ex_mem_read, if_id_rs, if_id_rt,
    input  if_id_use_rs, if_id_use_rt, npc_op, dmem_busy,
    output stall_if, bubble_ex, flush_ifid, freeze_all, state_o
`ifdef HAZ_PERF_CNT_EN
    , output perf_stall, perf_flush, perf_freeze
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: multi-cycle load-use
// stall, multi-cycle redirect flush, and data-memory busy freeze.
// Optional cycle counters for stall/flush/freeze are enabled by HAZ_PERF_CNT_EN.
//
// state  | meaning
// RUN    | no hazard in progress; detect and serve the first cycle combinationally
// LSTALL | remaining load-use stall cycles (stall PC/IF-ID, bubble ID/EX)
// BFLUSH | remaining wrong-path flush cycles after a redirect
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NPCOP_W  = 2,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    BFLUSH = 2'd2
  } state_t;

  // Counter reload: the detection cycle itself is the first served cycle.
  localparam logic [3:0] LD_RELOAD = 4'(LOAD_LAT - 1);
  localparam logic [3:0] BR_RELOAD = 4'(BR_FLUSH - 1);

  generate
    if (LOAD_LAT < 1 || LOAD_LAT > 15) begin : g_bad_load_lat
      $error("hazard_ctrl: LOAD_LAT must be in 1..15");
    end
    if (BR_FLUSH < 1 || BR_FLUSH > 15) begin : g_bad_br_flush
      $error("hazard_ctrl: BR_FLUSH must be in 1..15");
    end
  endgenerate

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [REG_AW-1:0]  ex_rt, id_rs, id_rt;
  logic [NPCOP_W-1:0] npc_op;
  logic               load_use, redirect;

  assign ex_rt  = hz.id_ex_rt;
  assign id_rs  = hz.if_id_rs;
  assign id_rt  = hz.if_id_rt;
  assign npc_op = hz.npc_op;

  // Hazard detection; $zero is never a real dependency.
  always_comb begin
    load_use = hz.id_ex_mem_read && (ex_rt != '0) &&
               (((ex_rt == id_rs) && hz.if_id_use_rs) ||
                ((ex_rt == id_rt) && hz.if_id_use_rt));
    redirect = (npc_op != '0);
  end

  // State and remaining-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and outputs; busy freeze overrides everything and holds progress.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hz.stall_if   = 1'b0;
    hz.bubble_ex  = 1'b0;
    hz.flush_ifid = 1'b0;
    hz.freeze_all = 1'b0;
    hz.state_o    = rst ? 2'd0 : state;
    if (rst) begin
      state_nxt = RUN;
      cnt_nxt   = 4'd0;
    end else if (hz.dmem_busy) begin
      hz.freeze_all = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            hz.stall_if  = 1'b1;
            hz.bubble_ex = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LSTALL;
              cnt_nxt   = LD_RELOAD;
            end
          end else if (redirect) begin
            hz.flush_ifid = 1'b1;
            if (BR_FLUSH > 1) begin
              state_nxt = BFLUSH;
              cnt_nxt   = BR_RELOAD;
            end
          end
        end
        LSTALL: begin
          hz.stall_if  = 1'b1;
          hz.bubble_ex = 1'b1;
          cnt_nxt      = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RUN;
        end
        BFLUSH: begin
          hz.flush_ifid = 1'b1;
          cnt_nxt       = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating cycle counters for stall, flush and freeze activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      hz.perf_stall  <= 32'd0;
      hz.perf_flush  <= 32'd0;
      hz.perf_freeze <= 32'd0;
    end else begin
      if (hz.stall_if && (hz.perf_stall != '1))    hz.perf_stall  <= hz.perf_stall + 32'd1;
      if (hz.flush_ifid && (hz.perf_flush != '1))  hz.perf_flush  <= hz.perf_flush + 32'd1;
      if (hz.freeze_all && (hz.perf_freeze != '1)) hz.perf_freeze <= hz.perf_freeze + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Three instances with different
// LOAD_LAT/BR_FLUSH share one stimulus stream; a remaining-cycles model checks
// every instance every cycle, and directed literals pin the model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [4:0] t_ex_rt, t_rs, t_rt;
  logic       t_mr, t_urs, t_urt, t_busy;
  logic [1:0] t_npc;

  hazard_if #(.REG_AW(5), .NPCOP_W(2)) hza (), hzb (), hzc ();

  hazard_ctrl #(.REG_AW(5), .NPCOP_W(2), .LOAD_LAT(2), .BR_FLUSH(3)) dut_a (.clk(clk), .rst(rst), .hz(hza));
  hazard_ctrl #(.REG_AW(5), .NPCOP_W(2), .LOAD_LAT(3), .BR_FLUSH(4)) dut_b (.clk(clk), .rst(rst), .hz(hzb));
  hazard_ctrl #(.REG_AW(5), .NPCOP_W(2), .LOAD_LAT(1), .BR_FLUSH(1)) dut_c (.clk(clk), .rst(rst), .hz(hzc));

  int ll_p [3] = '{2, 3, 1};
  int bf_p [3] = '{3, 4, 1};

  // observed {stall_if, bubble_ex, flush_ifid, freeze_all, state_o[1:0]}
  logic [5:0] obs [3];
  assign obs[0] = {hza.stall_if, hza.bubble_ex, hza.flush_ifid, hza.freeze_all, hza.state_o};
  assign obs[1] = {hzb.stall_if, hzb.bubble_ex, hzb.flush_ifid, hzb.freeze_all, hzb.state_o};
  assign obs[2] = {hzc.stall_if, hzc.bubble_ex, hzc.flush_ifid, hzc.freeze_all, hzc.state_o};

`ifdef HAZ_PERF_CNT_EN
  logic [95:0] pobs [3];
  assign pobs[0] = {hza.perf_stall, hza.perf_flush, hza.perf_freeze};
  assign pobs[1] = {hzb.perf_stall, hzb.perf_flush, hzb.perf_freeze};
  assign pobs[2] = {hzc.perf_stall, hzc.perf_flush, hzc.perf_freeze};
  logic [31:0] mp [3][3];
  initial for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mp[i][j] = 32'd0;
`endif

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [1:0] npc, input logic busy);
    t_mr = mr; t_ex_rt = ex_rt; t_rs = rs; t_urs = urs; t_rt = rt; t_urt = urt;
    t_npc = npc; t_busy = busy;
    hza.id_ex_mem_read = mr; hza.id_ex_rt = ex_rt; hza.if_id_rs = rs; hza.if_id_use_rs = urs;
    hza.if_id_rt = rt; hza.if_id_use_rt = urt; hza.npc_op = npc; hza.dmem_busy = busy;
    hzb.id_ex_mem_read = mr; hzb.id_ex_rt = ex_rt; hzb.if_id_rs = rs; hzb.if_id_use_rs = urs;
    hzb.if_id_rt = rt; hzb.if_id_use_rt = urt; hzb.npc_op = npc; hzb.dmem_busy = busy;
    hzc.id_ex_mem_read = mr; hzc.id_ex_rt = ex_rt; hzc.if_id_rs = rs; hzc.if_id_use_rs = urs;
    hzc.if_id_rt = rt; hzc.if_id_use_rt = urt; hzc.npc_op = npc; hzc.dmem_busy = busy;
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 2'd0, 0); endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic lit(input string nm, input int idx, input logic [5:0] exp);
    @(negedge clk);
    chk(nm, {90'd0, obs[idx]}, {90'd0, exp});
  endtask

  // Model: counts of stall/flush cycles still owed; busy holds them.
  int sl [3] = '{0, 0, 0};
  int fl [3] = '{0, 0, 0};

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    logic       lu, rd;
    logic [5:0] e;
    lu = t_mr && (t_ex_rt != 5'd0) &&
         (((t_ex_rt == t_rs) && t_urs) || ((t_ex_rt == t_rt) && t_urt));
    rd = (t_npc != 2'd0);
    for (int i = 0; i < 3; i++) begin
      e = 6'd0;
      if (rst) begin
        sl[i] = 0; fl[i] = 0;
      end else if (t_busy) begin
        e[2] = 1'b1;
        e[1:0] = (sl[i] > 0) ? 2'd1 : ((fl[i] > 0) ? 2'd2 : 2'd0);
      end else if (sl[i] > 0) begin
        e[5] = 1'b1; e[4] = 1'b1; e[1:0] = 2'd1; sl[i] = sl[i] - 1;
      end else if (fl[i] > 0) begin
        e[3] = 1'b1; e[1:0] = 2'd2; fl[i] = fl[i] - 1;
      end else if (lu) begin
        e[5] = 1'b1; e[4] = 1'b1; sl[i] = ll_p[i] - 1;
      end else if (rd) begin
        e[3] = 1'b1; fl[i] = bf_p[i] - 1;
      end
      checks++;
      if (obs[i] !== e) begin
        fails++;
        $display("FAIL model_dut%0d got=%b exp=%b t=%0t", i, obs[i], e, $time);
      end
`ifdef HAZ_PERF_CNT_EN
      checks++;
      if (pobs[i] !== {mp[i][0], mp[i][1], mp[i][2]}) begin
        fails++;
        $display("FAIL perf_dut%0d got=%0h exp=%0h t=%0t", i, pobs[i], {mp[i][0], mp[i][1], mp[i][2]}, $time);
      end
      if (rst) begin
        mp[i][0] = 0; mp[i][1] = 0; mp[i][2] = 0;
      end else begin
        if (e[5] && mp[i][0] != 32'hFFFF_FFFF) mp[i][0] = mp[i][0] + 1;
        if (e[3] && mp[i][1] != 32'hFFFF_FFFF) mp[i][1] = mp[i][1] + 1;
        if (e[2] && mp[i][2] != 32'hFFFF_FFFF) mp[i][2] = mp[i][2] + 1;
      end
`endif
    end
  end

  // Back-to-back vector on the purely combinational instance (LOAD_LAT=BR_FLUSH=1).
  task automatic vec_c(input string nm, input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [1:0] npc, input logic busy, input logic [5:0] exp);
    drive(mr, ex_rt, rs, urs, rt, urt, npc, busy);
    lit(nm, 2, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    lit("reset_a", 0, 6'b000000);
    lit("reset_b", 1, 6'b000000);
    tick(); tick();
    rst = 1'b0;
    repeat (2) tick();

    // load-use, LOAD_LAT=2 on A: stall 2 cycles, state 0,1,0
    drive(1, 5'd5, 5'd5, 1, 5'd0, 0, 2'd0, 0);
    lit("lu_c0", 0, 6'b110000); tick();
    idle();
    lit("lu_c1", 0, 6'b110001); tick();
    lit("lu_c2", 0, 6'b000000);
    repeat (4) tick();

    // $zero and usage qualification
    drive(1, 5'd0, 5'd0, 1, 5'd0, 0, 2'd0, 0);
    lit("zero_a", 0, 6'b000000); lit("zero_c", 2, 6'b000000); tick();
    drive(1, 5'd7, 5'd3, 1, 5'd7, 0, 2'd0, 0);
    lit("unused_rt_a", 0, 6'b000000); tick();
    idle(); repeat (2) tick();

    // redirect, BR_FLUSH=3 on A, second redirect ignored
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    lit("br_c0", 0, 6'b001000); tick();
    lit("br_c1", 0, 6'b001010); tick();
    idle();
    lit("br_c2", 0, 6'b001010); tick();
    lit("br_c3_noext", 0, 6'b000000);
    repeat (3) tick();

    // load-use beats redirect, redirect re-presented after the stall
    drive(1, 5'd9, 5'd9, 1, 5'd0, 0, 2'd2, 0);
    lit("prio_c0", 0, 6'b110000); tick();
    lit("prio_c1", 0, 6'b110001); tick();
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd2, 0);
    lit("prio_c2", 0, 6'b001000); tick();
    idle();
    repeat (6) tick();

    // busy freeze mid-LSTALL on B (LOAD_LAT=3, cnt=2 when frozen)
    drive(1, 5'd4, 5'd0, 0, 5'd4, 1, 2'd0, 0);
    lit("frz_c0", 1, 6'b110000); tick();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd0, 1);
      lit($sformatf("frz_c%0d", k), 1, 6'b000101); tick();
    end
    idle();
    lit("frz_c5", 1, 6'b110001); tick();
    lit("frz_c6", 1, 6'b110001); tick();
    lit("frz_c7", 1, 6'b000000);
    repeat (2) tick();

    // reset in the second flush cycle on B (BR_FLUSH=4)
    drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd1, 0);
    lit("rstbf_c0", 1, 6'b001000); tick();
    idle(); rst = 1'b1;
    lit("rstbf_c1", 1, 6'b000000); tick();
    rst = 1'b0;
    lit("rstbf_c2", 1, 6'b000000);
`ifdef HAZ_PERF_CNT_EN
    chk("rstbf_perf", pobs[1], 96'd0);
`endif
    tick();

    // back-to-back hazards, combinational instance C
    vec_c("b2b_lu",     1, 5'd3, 5'd3, 1, 5'd0, 0, 2'd0, 0, 6'b110000);
    vec_c("b2b_rd",     0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd1, 0, 6'b001000);
    vec_c("b2b_lu_rd",  1, 5'd3, 5'd3, 1, 5'd0, 0, 2'd3, 0, 6'b110000);
    vec_c("b2b_rd2",    0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd2, 0, 6'b001000);
    vec_c("b2b_lu_rt",  1, 5'd6, 5'd6, 0, 5'd6, 1, 2'd0, 0, 6'b110000);
    vec_c("b2b_idle",   0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd0, 0, 6'b000000);
    vec_c("b2b_busy",   1, 5'd3, 5'd3, 1, 5'd0, 0, 2'd1, 1, 6'b000100);
    vec_c("b2b_after",  0, 5'd0, 5'd0, 0, 5'd0, 0, 2'd0, 0, 6'b000000);

    idle();
    repeat (8) tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core; generalises the load-use/branch hazard detector.
- Adds multi-cycle load-use stalls, multi-cycle branch flush, source-usage qualification, $zero exclusion, and a data-memory busy freeze.
- Sits beside the ID stage.
- Drives the PC/IF-ID write enables, the ID/EX bubble mux, the IF/ID flush and the global pipeline freeze.

Parameters:
REG_AW, 5, register address width.
NPCOP_W, 2, width of the next-PC op select. Zero means sequential PC; nonzero means redirect.
LOAD_LAT, 1, stall cycles inserted per load-use hazard; legal range 1..15.
BR_FLUSH, 1, IF/ID flush cycles per redirect; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous active-high reset.
id_ex_rt  in  REG_AW  destination register of the instruction in EX.
id_ex_mem_read  in  1  instruction in EX is a load.
if_id_rs  in  REG_AW  rs of the instruction in ID.
if_id_rt  in  REG_AW  rt of the instruction in ID.
if_id_use_rs  in  1  ID instruction reads rs.
if_id_use_rt  in  1  ID instruction reads rt.
npc_op  in  NPCOP_W  next-PC op from ID; nonzero means taken redirect.
dmem_busy  in  1  data memory not ready this cycle.
stall_if  out  1  hold PC and IF/ID.
bubble_ex  out  1  load zeroed controls into ID/EX.
flush_ifid  out  1  replace IF/ID with NOP.
freeze_all  out  1  hold every pipeline register.
state_o  out  2  FSM state: 0 = RUN, 1 = LSTALL, 2 = BFLUSH.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset:
  - state goes to RUN and cnt (4-bit) goes to 0.
  - While rst=1, all outputs are forced to 0, combinationally.
- Hazard terms (combinational):
  - load_use = id_ex_mem_read & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs & if_id_use_rs) | (id_ex_rt == if_id_rt & if_id_use_rt)).
  - redirect = (npc_op != 0).
- First-cycle response: the first stall or flush cycle is asserted combinationally in the detection cycle, with zero latency. Further cycles are counter-driven.
- dmem_busy:
  - Top priority in every state.
  - freeze_all=1; stall_if, bubble_ex and flush_ifid are 0.
  - state and cnt are held, and new hazards are ignored.
  - Work resumes the cycle after dmem_busy falls, with the remaining count intact.
- RUN, when not busy:
  - load_use: stall_if=1, bubble_ex=1. If LOAD_LAT>1, go to LSTALL with cnt=LOAD_LAT-1.
  - Load-use beats redirect: a redirect computed from a stale operand is discarded, and the branch re-evaluates after the stall.
  - Otherwise redirect: flush_ifid=1. If BR_FLUSH>1, go to BFLUSH with cnt=BR_FLUSH-1.
  - Otherwise all outputs are 0.
- LSTALL: stall_if=1, bubble_ex=1, cnt decrements. When cnt==1, the next state is RUN. redirect and load_use inputs are ignored.
- BFLUSH: flush_ifid=1, cnt decrements. When cnt==1, the next state is RUN. Further redirects are ignored because they come from wrong-path fetch.
- After returning to RUN, hazards are re-evaluated normally in that cycle. A still-present load_use restarts the stall.
- Back-to-back cases:
  - Consecutive independent hazards are each fully served; there are no idle gaps required.
  - With LOAD_LAT=BR_FLUSH=1 the FSM never leaves RUN, which equals a purely combinational detector.
- Reset mid-LSTALL, mid-BFLUSH or mid-freeze returns to RUN next edge, with outputs 0 during reset.
- Out-of-range parameters: out-of-range LOAD_LAT or BR_FLUSH is a $error at elaboration.

Optional Feature:
HAZ_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall [31:0], perf_flush [31:0] and perf_freeze [31:0].
  - Each counts cycles with stall_if, flush_ifid or freeze_all respectively high.
  - Counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Load-use, LOAD_LAT=2: EX lw rt=5, ID add rs=5 use_rs=1 -> stall_if and bubble_ex high for exactly 2 cycles; state_o goes 0,1,0.
- $zero and usage: lw rt=0 with rs=0, or lw rt=7 with ID rt=7 but use_rt=0 -> no stall, all outputs 0.
- Redirect, BR_FLUSH=3: npc_op=2'b01 in RUN -> flush_ifid high 3 cycles. A second redirect in cycle 2 is ignored, with no extension.
- Priority: load_use and npc_op=2'b10 in the same cycle -> stall_if=1, flush_ifid=0. After the stall, the redirect is re-presented -> flush_ifid=1.
- Freeze: dmem_busy=1 for 4 cycles mid-LSTALL with cnt=2 -> freeze_all=1 and the others 0 for 4 cycles. Then the stall resumes for the remaining 2 cycles.
- Reset mid-BFLUSH, BR_FLUSH=4: rst in flush cycle 2 -> outputs 0, state_o=0 after the edge. With HAZ_PERF_CNT_EN defined, perf counters read 0.
